// File: rtl/toggle_bank_arbiter_if.sv
// Bus bundle between the requester FSMs and the shared toggle bank.
// The master side drives requests and clear; the slave side (the arbiter)
// returns grant, bank state, error and busy.
interface toggle_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] req_idx;
  logic                 clr;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_id;
  logic [WIDTH-1:0]     q;
  logic                 err;
  logic                 busy;

  modport master (
    output req, req_idx, clr,
    input  gnt, gnt_id, q, err, busy
  );

  modport slave (
    input  req, req_idx, clr,
    output gnt, gnt_id, q, err, busy
  );
endinterface

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter sharing one bank of toggle flops between NREQ
// requesters. One grant per clock; the winner's bit toggles on the same
// edge that raises its grant. A requester granted in this cycle is held
// off for one cycle so a single handshake never yields two toggles.
module toggle_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  toggle_bank_arbiter_if.slave bus
);

  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic [IDW-1:0]   r_ptr;

  logic [NREQ-1:0]  w_elig;
  logic             w_win_vld;
  logic [IDW-1:0]   w_win_id;
  logic [IDXW-1:0]  w_win_idx;
  logic             w_idx_ok;
  int               w_dist;
  int               w_best;

  logic [NREQ-1:0]  w_gnt_nxt;
  logic [IDW-1:0]   w_gnt_id_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_err_nxt;
  logic [IDW-1:0]   w_ptr_nxt;

  // Requests granted this cycle sit out one cycle (handshake holdoff).
  assign w_elig = bus.req & ~r_gnt;

  // Winner is the eligible requester closest to ptr going upward, modulo NREQ.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_dist    = 0;
    w_best    = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (w_elig[i]) begin
        w_dist = (i + NREQ - int'(r_ptr)) % NREQ;
        if (w_dist < w_best) begin
          w_best    = w_dist;
          w_win_id  = IDW'(i);
          w_win_vld = 1'b1;
        end
      end
    end
  end

  // Only the winner's index slice is looked at, so junk on losers' slices
  // never reaches the bank.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_id == IDW'(i)) begin
        w_win_idx = bus.req_idx[i*IDXW +: IDXW];
      end
    end
  end

  assign w_idx_ok = (int'(w_win_idx) < WIDTH);

  // Next-state for grant, bank and pointer; clear overrides arbitration.
  always_comb begin
    w_gnt_nxt    = '0;
    w_gnt_id_nxt = r_gnt_id;
    w_q_nxt      = r_q;
    w_err_nxt    = 1'b0;
    w_ptr_nxt    = r_ptr;
    if (bus.clr) begin
      w_q_nxt = '0;
    end else if (w_win_vld) begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_win_id == IDW'(i)) begin
          w_gnt_nxt[i] = 1'b1;
        end
      end
      w_gnt_id_nxt = w_win_id;
      w_ptr_nxt    = IDW'((int'(w_win_id) + 1) % NREQ);
      if (w_idx_ok) begin
        for (int b = 0; b < WIDTH; b++) begin
          if (int'(w_win_idx) == b) begin
            w_q_nxt[b] = ~r_q[b];
          end
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  // State registers; async reset also drops any toggle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_q      <= '0;
      r_err    <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_q      <= w_q_nxt;
      r_err    <= w_err_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_gnt_id;
  assign bus.q      = r_q;
  assign bus.err    = r_err;
  assign bus.busy   = |(bus.req & ~r_gnt) & ~bus.clr;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Directed bench for toggle_bank_arbiter: a vector table for the main
// arbitration behaviour plus hand sequences for async reset and the
// out-of-range index case on a WIDTH=6 instance.
module tb_toggle_bank_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toggle_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .IDXW(3), .IDW(2)) b8 ();
  toggle_bank_arbiter_if #(.NREQ(4), .WIDTH(6), .IDXW(3), .IDW(2)) b6 ();

  toggle_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3), .IDW(2)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  toggle_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3), .IDW(2)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [11:0] idx;
    bit         clr;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] q;
    bit         err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [11:0] idx, bit clr,
                              logic [3:0] gnt, logic [1:0] id, logic [7:0] q, bit err);
    vec_t v;
    v.rst = rst; v.req = req; v.idx = idx; v.clr = clr;
    v.gnt = gnt; v.id = id; v.q = q; v.err = err;
    return v;
  endfunction

  function automatic logic [11:0] ix(int a3, int a2, int a1, int a0);
    return {a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    b8.req = '0; b8.req_idx = '0; b8.clr = 1'b0;
    b6.req = '0; b6.req_idx = '0; b6.clr = 1'b0;

    // rst  req      idx            clr  gnt      id  q      err
    tbl.push_back(mk(1, 4'b0001, ix(0,0,0,3), 0, 4'b0001, 0, 8'h08, 0));
    tbl.push_back(mk(0, 4'b0001, ix(0,0,0,3), 0, 4'b0000, 0, 8'h08, 0));
    tbl.push_back(mk(0, 4'b0001, ix(0,0,0,3), 0, 4'b0001, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0000, ix(0,0,0,3), 0, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, ix(7,5,2,0), 0, 4'b0001, 0, 8'h01, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0010, 1, 8'h05, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0100, 2, 8'h25, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b1000, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0001, 0, 8'hA4, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0010, 1, 8'hA0, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0100, 2, 8'h80, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b1000, 3, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0000, ix(7,5,2,0), 0, 4'b0000, 3, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0100, ix(0,5,0,0), 0, 4'b0100, 2, 8'h20, 0));
    tbl.push_back(mk(0, 4'b0101, ix(0,5,0,0), 0, 4'b0001, 0, 8'h21, 0));
    tbl.push_back(mk(0, 4'b0101, ix(0,5,0,0), 0, 4'b0100, 2, 8'h01, 0));
    tbl.push_back(mk(0, 4'b0000, ix(0,5,0,0), 0, 4'b0000, 2, 8'h01, 0));
    tbl.push_back(mk(0, 4'b0001, ix(0,5,0,0), 0, 4'b0001, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0000, ix(0,5,0,0), 0, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0101, ix(0,5,0,0), 0, 4'b0100, 2, 8'h20, 0));
    tbl.push_back(mk(0, 4'b0000, ix(0,5,0,0), 0, 4'b0000, 2, 8'h20, 0));
    tbl.push_back(mk(1, 4'b1111, ix(7,5,2,0), 0, 4'b0001, 0, 8'h01, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0010, 1, 8'h05, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b0100, 2, 8'h25, 0));
    tbl.push_back(mk(0, 4'b1111, ix(7,5,2,0), 0, 4'b1000, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 4'b1111, ix(6,4,3,1), 0, 4'b0001, 0, 8'hA7, 0));
    tbl.push_back(mk(0, 4'b1111, ix(6,4,3,1), 0, 4'b0010, 1, 8'hAF, 0));
    tbl.push_back(mk(0, 4'b1111, ix(6,4,3,1), 0, 4'b0100, 2, 8'hBF, 0));
    tbl.push_back(mk(0, 4'b1111, ix(6,4,3,1), 0, 4'b1000, 3, 8'hFF, 0));
    tbl.push_back(mk(0, 4'b0010, ix(0,0,4,0), 1, 4'b0000, 3, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0010, ix(0,0,4,0), 0, 4'b0010, 1, 8'h10, 0));
    tbl.push_back(mk(0, 4'b0000, ix(0,0,4,0), 0, 4'b0000, 1, 8'h10, 0));

    // Reset state while rst_n is low.
    #7;
    chk("reset q", 32'(b8.q), 32'h0);
    chk("reset gnt", 32'(b8.gnt), 32'h0);
    chk("reset gnt_id", 32'(b8.gnt_id), 32'h0);
    chk("reset err", 32'(b8.err), 32'h0);
    #5;
    rst_n = 1'b1;
    step();

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].rst) pulse_reset();
      b8.req     = tbl[n].req;
      b8.req_idx = tbl[n].idx;
      b8.clr     = tbl[n].clr;
      #1;
      chk($sformatf("v%0d busy", n), 32'(b8.busy), 32'(tbl[n].gnt != 4'b0000));
      step();
      chk($sformatf("v%0d gnt", n), 32'(b8.gnt), 32'(tbl[n].gnt));
      chk($sformatf("v%0d gnt_id", n), 32'(b8.gnt_id), 32'(tbl[n].id));
      chk($sformatf("v%0d q", n), 32'(b8.q), 32'(tbl[n].q));
      chk($sformatf("v%0d err", n), 32'(b8.err), 32'(tbl[n].err));
    end

    // Async reset mid-cycle with q=A5 and a grant pending.
    b8.req = '0; b8.clr = 1'b0;
    pulse_reset();
    b8.req = 4'b1111; b8.req_idx = ix(7,5,2,0);
    for (int k = 0; k < 4; k++) step();
    chk("pre-reset q", 32'(b8.q), 32'hA5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset q", 32'(b8.q), 32'h0);
    chk("async reset gnt", 32'(b8.gnt), 32'h0);
    chk("async reset err", 32'(b8.err), 32'h0);
    step();
    chk("held reset q", 32'(b8.q), 32'h0);
    chk("held reset gnt", 32'(b8.gnt), 32'h0);
    b8.req = '0;
    #2;
    rst_n = 1'b1;
    step();
    chk("post reset q", 32'(b8.q), 32'h0);

    // Out-of-range index on the WIDTH=6 instance.
    b6.req = 4'b0001; b6.req_idx = ix(0,0,0,7);
    step();
    chk("w6 idx7 gnt", 32'(b6.gnt), 32'h1);
    chk("w6 idx7 err", 32'(b6.err), 32'h1);
    chk("w6 idx7 q", 32'(b6.q), 32'h0);
    b6.req_idx = ix(0,0,0,6);
    step();
    chk("w6 holdoff gnt", 32'(b6.gnt), 32'h0);
    chk("w6 holdoff err", 32'(b6.err), 32'h0);
    step();
    chk("w6 idx6 gnt", 32'(b6.gnt), 32'h1);
    chk("w6 idx6 err", 32'(b6.err), 32'h1);
    chk("w6 idx6 q", 32'(b6.q), 32'h0);
    b6.req = 4'b0000;
    step();
    chk("w6 idle err", 32'(b6.err), 32'h0);
    b6.req = 4'b0001; b6.req_idx = ix(0,0,0,5);
    step();
    chk("w6 idx5 q", 32'(b6.q), 32'h20);
    chk("w6 idx5 err", 32'(b6.err), 32'h0);
    b6.req = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
